// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter sharing one 4:1 data mux, bursts bounded to HOLD beats
module mux_rr_arbiter #(
  parameter int W    = 8,
  parameter int HOLD = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] din,
  input  logic           out_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [3:0]     gnt,
  output logic [1:0]     sel,
  output logic [3:0]     ack,
  output logic           busy
);
  localparam int CW = $clog2(HOLD + 1);
  localparam logic [CW-1:0] LAST = CW'(HOLD - 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [1:0] ptr, pick;
  logic [CW-1:0] cnt;
  logic accept;
  always_comb begin
    pick = ptr;
    for (int k = 3; k >= 0; k--)
      if (req[ptr + 2'(k)]) pick = ptr + 2'(k);
  end
  assign busy      = state == BUSY;
  assign out_valid = busy & req[sel];
  assign out_data  = out_valid ? din[32'(sel)*W +: W] : '0;
  assign ack       = (busy & out_ready) ? (gnt & req) : 4'b0;
  assign accept    = out_valid & out_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      sel   <= '0;
      gnt   <= '0;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (|req) begin
        sel   <= pick;
        gnt   <= 4'b1 << pick;
        cnt   <= '0;
        state <= BUSY;
      end
    end else begin
      if (accept) cnt <= cnt + CW'(1);
      // sel is kept after release; only ptr moves to rotate priority
      if ((accept && cnt == LAST) || !req[sel]) begin
        ptr   <= sel + 2'd1;
        gnt   <= '0;
        state <= IDLE;
      end
    end
  end
endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer that shares one 4:1 data multiplexer among four requesters. It selects the granted lane, drives the mux select lines `sel[1:0]` (`sel[1]`=s1, `sel[0]`=s0), and passes that lane's data to a single valid/ready output channel. It bounds each grant to a burst of `HOLD` beats. It sits between four producer lanes and one shared consumer.

## Interface
- `W`, 8, data width per lane (≥1)
- `HOLD`, 4, max accepted beats per grant (1..256); beat counter width is `$clog2(HOLD+1)`

- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous, active-high reset
- `req`  input  4  request per lane, level, held while lane has data
- `din`  input  4*W  lane data, lane i at `din[i*W +: W]`
- `out_ready`  input  1  consumer accepts beat this cycle
- `out_valid`  output  1  beat presented on `out_data`
- `out_data`  output  W  data of granted lane, 0 when no grant
- `gnt`  output  4  one-hot registered grant, 0 when idle
- `sel`  output  2  registered mux select = index of granted lane
- `ack`  output  4  per-lane beat accepted; lane advances its data on this
- `busy`  output  1  high in BUSY state

## Operation
- Two states: IDLE, BUSY. Registers: `state`, `ptr[1:0]`, `sel`, `gnt`, `cnt`.
- IDLE:
  - If `req != 0`, pick the first lane with req set, searching `ptr, ptr+1, ptr+2, ptr+3` (mod 4).
  - Load `sel` = that lane, `gnt` = one-hot of it, `cnt` = 0, and go to BUSY.
  - Else stay in IDLE with `gnt` = 0.
- BUSY:
  - `out_valid = req[sel]`.
  - `out_data = din[sel*W +: W]` when `out_valid`, else 0.
  - `ack[i] = gnt[i] & req[i] & out_ready`.
  - Beat accepted = `out_valid & out_ready`; on acceptance, `cnt` increments.
  - Release when either:
    - a beat is accepted with `cnt == HOLD-1`, or
    - `req[sel] == 0` (lane withdrew).
  - On release: `ptr <= sel+1` (mod 4), `gnt <= 0`, `state <= IDLE`. `sel` keeps its value.
- Releasing always rotates priority, even for a 1-beat grant or a withdrawn request.
- `out_ready` low in BUSY: no beat is accepted, `cnt` holds, and the grant is kept (no timeout).
- Combinational outputs (`out_valid`, `out_data`, `ack`) are 0 whenever `state == IDLE`.
- `busy = (state == BUSY)`.
- Simultaneous final beat and `req[sel]` drop cannot occur, since acceptance requires `req[sel]=1`. Final beat plus other lanes requesting: release, then re-arbitrate from the new `ptr` in IDLE.
- A lane raising `req` while another lane holds the grant waits. No preemption.
- `HOLD = 1`: every grant carries exactly one beat.

## Timing
- Reset (async, immediate): `state` = IDLE, `ptr` = 0, `sel` = 0, `gnt` = 0, `cnt` = 0. Hence `out_valid` = 0, `out_data` = 0, `ack` = 0, `busy` = 0.
- Reset asserted mid-burst aborts the grant with no final ack. After deassertion, lane 0 has top priority.
- Grant latency: a req sampled in IDLE at edge n gives `gnt`/`sel`/`busy` valid after edge n. The first beat can be accepted in cycle n+1.
- Turnaround: release at edge m is followed by an IDLE cycle, with the next grant after edge m+1. Each grant therefore costs one dead cycle.
- Throughput within a grant: one beat per cycle while `req[sel]` and `out_ready` are both high.
- `sel` and `gnt` change only on clock edges. The mux select never glitches within a cycle.

## Test plan
- Reset: assert `rst` mid-burst (lane 2, `cnt`=2). All outputs go 0 immediately, without waiting for a clock edge. After release, `req`=4'b1111 → `gnt`=0001, `sel`=0.
- Round-robin: `req`=4'b1111 held, `out_ready`=1, `HOLD`=4.
  - Grants go 0,1,2,3,0, with 4 acks each.
  - Each grant is separated by one IDLE cycle.
  - `out_data` equals the lane's `din` on every ack.
- Withdrawal: lane 1 granted, drops `req` after 2 beats → release next edge, `ptr`=2. With `req`=4'b1011 the next grant is lane 3, not lane 0.
- Backpressure: lane 3 granted, `out_ready`=0 for 5 cycles → `out_valid`=1, `ack`=0, `cnt` stays 0, `gnt` is held. Raising `out_ready` completes 4 beats, then `ptr`=0.
- `HOLD`=1 with `req`=4'b0101 → grants alternate 0,2,0,2, with one ack each.
- Idle: `req`=0 → `gnt`=0, `out_valid`=0, `out_data`=0, `busy`=0 indefinitely. A single `req[2]` pulse is granted the next cycle, and its drop releases the grant.
